// File: rtl/clb_cfg_pkg.sv
// -----------------------------------------------------------------------------
// clb_cfg_pkg
// Shared types and constants for the CLB serial configuration loader.
//   state_e      : loader FSM states
//   ERR_*        : err_code encodings
//   CLB_SYNC     : default sync byte that precedes the frame count
//   CLB_CFG_W    : default configuration frame width
//   *_LSB/FL_BIT : bit offsets of the fields inside one configuration frame
// -----------------------------------------------------------------------------
package clb_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HUNT  = 3'd1,
        COUNT = 3'd2,
        FRAME = 3'd3,
        PAR   = 3'd4,
        CRC   = 3'd5,
        DONE  = 3'd6,
        ERROR = 3'd7
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_COUNT  = 2'b10;
    localparam logic [1:0] ERR_CRC    = 2'b11;

    localparam logic [7:0] CLB_SYNC  = 8'hA5;
    localparam int         CLB_CFG_W = 37;

    // Frame layout, MSB first on the wire:
    // mem[15:0] | comboption[1:0] | mux2..mux6 sel (10) | o2m (6) | DQmux (2) | floporlatch
    localparam int MEM_LSB    = 21;
    localparam int COMB_LSB   = 19;
    localparam int MUXSEL_LSB = 9;
    localparam int O2M_LSB    = 3;
    localparam int DQ_LSB     = 1;
    localparam int FL_BIT     = 0;

endpackage

// File: rtl/clb_cfg_crc16.sv
// -----------------------------------------------------------------------------
// clb_cfg_crc16
// Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first).
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset (register returns to init value)
//   clr_i   : synchronous re-initialise to 0xFFFF (wins over en_i)
//   en_i    : fold din_i into the CRC this cycle
//   din_i   : serial data bit
//   crc_o   : current CRC register
// -----------------------------------------------------------------------------
module clb_cfg_crc16 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        din_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb_s;

    assign fb_s  = crc_q[15] ^ din_i;
    assign crc_d = {crc_q[14:0], 1'b0} ^ (fb_s ? 16'h1021 : 16'h0000);
    assign crc_o = crc_q;

    // CRC register: re-initialised on clear, advanced one bit per enable.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= 16'hFFFF;
        end else if (clr_i) begin
            crc_q <= 16'hFFFF;
        end else if (en_i) begin
            crc_q <= crc_d;
        end else begin
            crc_q <= crc_q;
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
// Serial configuration controller for the CLB array. Hunts for a sync byte,
// reads a 16-bit frame count, then deserialises one CFG_W-bit frame plus an
// even-parity bit per CLB and writes each good frame to the addressed CLB.
// Optional trailing CRC-16 check is enabled by defining CLB_CFG_CRC_EN.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse; aborts any load and re-enters HUNT
//   din, din_valid      : serial bit (MSB first) and its qualifier
//   cfg_data/addr/we    : parallel frame write port (one-cycle strobe)
//   busy, done, err     : status (done and err are sticky until start)
//   err_code            : 01 parity, 10 bad count, 11 CRC
// -----------------------------------------------------------------------------
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int         NUM_CLB = 64,
    parameter int         CFG_W   = CLB_CFG_W,
    parameter logic [7:0] SYNC    = CLB_SYNC,
    parameter int         AW      = $clog2(NUM_CLB)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    output logic [CFG_W-1:0] cfg_data,
    output logic [AW-1:0]    cfg_addr,
    output logic             cfg_we,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    // One counter serves both the 16-bit count field and the frame body.
    localparam int BW = $clog2(CFG_W);

    state_e           state_q;
    logic [CFG_W-1:0] shift_q;
    logic [CFG_W-1:0] shift_d;
    logic [BW-1:0]    bitcnt_q;
    logic [15:0]      count_q;
    logic [15:0]      count_d;
    logic [CFG_W-1:0] cfg_data_q;
    logic [AW-1:0]    cfg_addr_q;
    logic             cfg_we_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             count_bad;
    logic             last_frame;
    logic             par_ok;

    function automatic logic even_parity_ok(input logic [CFG_W-1:0] frame,
                                            input logic             par_bit);
        even_parity_ok = ~((^frame) ^ par_bit);
    endfunction

    assign shift_d    = {shift_q[CFG_W-2:0], din};
    assign count_d    = {shift_q[14:0], din};
    assign count_bad  = (count_d == 16'd0) || (count_d > 16'(NUM_CLB));
    assign par_ok     = even_parity_ok(shift_q, din);
    // cfg_addr_q is the index of the frame currently being received.
    assign last_frame = ({{(16-AW){1'b0}}, cfg_addr_q} == (count_q - 16'd1));

`ifdef CLB_CFG_CRC_EN
    logic [15:0] crc_s;
    logic        crc_en;

    // CRC covers every frame and parity bit after the count field.
    assign crc_en = din_valid & ~start & ((state_q == FRAME) | (state_q == PAR));

    clb_cfg_crc16 u_crc (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (start),
        .en_i    (crc_en),
        .din_i   (din),
        .crc_o   (crc_s)
    );
`endif

    // Loader FSM with registered outputs; start overrides everything, and
    // din_valid low freezes all shifting and counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            count_q    <= 16'd0;
            cfg_data_q <= '0;
            cfg_addr_q <= '0;
            cfg_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            cfg_we_q <= 1'b0;
            // Address advances on the edge that ends the strobe.
            if (cfg_we_q) begin
                cfg_addr_q <= cfg_addr_q + AW'(1);
            end
            if (start) begin
                state_q    <= HUNT;
                shift_q    <= '0;
                bitcnt_q   <= '0;
                count_q    <= 16'd0;
                cfg_addr_q <= '0;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end else if (din_valid) begin
                case (state_q)
                    HUNT: begin
                        if (shift_d[7:0] == SYNC) begin
                            state_q  <= COUNT;
                            shift_q  <= '0;
                            bitcnt_q <= '0;
                        end else begin
                            shift_q <= shift_d;
                        end
                    end
                    COUNT: begin
                        if (bitcnt_q == BW'(15)) begin
                            count_q  <= count_d;
                            shift_q  <= '0;
                            bitcnt_q <= '0;
                            if (count_bad) begin
                                state_q    <= ERROR;
                                busy_q     <= 1'b0;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_COUNT;
                            end else begin
                                state_q <= FRAME;
                            end
                        end else begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + BW'(1);
                        end
                    end
                    FRAME: begin
                        shift_q <= shift_d;
                        if (bitcnt_q == BW'(CFG_W - 1)) begin
                            state_q  <= PAR;
                            bitcnt_q <= '0;
                        end else begin
                            bitcnt_q <= bitcnt_q + BW'(1);
                        end
                    end
                    PAR: begin
                        if (par_ok) begin
                            cfg_data_q <= shift_q;
                            cfg_we_q   <= 1'b1;
                            shift_q    <= '0;
                            if (last_frame) begin
`ifdef CLB_CFG_CRC_EN
                                state_q <= CRC;
`else
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end else begin
                                state_q <= FRAME;
                            end
                        end else begin
                            state_q    <= ERROR;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_PARITY;
                        end
                    end
`ifdef CLB_CFG_CRC_EN
                    CRC: begin
                        if (bitcnt_q == BW'(15)) begin
                            bitcnt_q <= '0;
                            shift_q  <= '0;
                            busy_q   <= 1'b0;
                            if (count_d == crc_s) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= ERROR;
                                err_q      <= 1'b1;
                                err_code_q <= ERR_CRC;
                            end
                        end else begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + BW'(1);
                        end
                    end
`endif
                    default: begin
                        // IDLE, DONE and ERROR ignore din.
                        state_q <= state_q;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign cfg_data = cfg_data_q;
    assign cfg_addr = cfg_addr_q;
    assign cfg_we   = cfg_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_cfg_loader
// Directed self-checking bench for clb_cfg_loader. Inputs are driven on the
// falling edge; outputs are sampled on the falling edge. CRC-specific steps
// are compiled in when CLB_CFG_CRC_EN is defined.
// -----------------------------------------------------------------------------
module tb_clb_cfg_loader;

    localparam int NUM_CLB = 64;
    localparam int CFG_W   = 37;
    localparam int AW      = 6;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic             din       = 1'b0;
    logic             din_valid = 1'b0;
    logic [CFG_W-1:0] cfg_data;
    logic [AW-1:0]    cfg_addr;
    logic             cfg_we;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    clb_cfg_loader #(.NUM_CLB(NUM_CLB), .CFG_W(CFG_W), .SYNC(8'hA5), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .cfg_data  (cfg_data),
        .cfg_addr  (cfg_addr),
        .cfg_we    (cfg_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Strobe log filled by the monitor, expectations filled by the driver.
    logic [AW-1:0]    log_addr [8];
    logic [CFG_W-1:0] log_data [8];
    int               log_cyc  [8];
    logic [CFG_W-1:0] exp_data [8];
    int               exp_cyc  [8];
    int               we_n   = 0;
    int               n_exp  = 0;
    bit               b2b    = 1'b0;
    bit               prev_we = 1'b0;
    bit               gap_en = 1'b0;
    logic [15:0]      tb_crc = 16'hFFFF;

    // Monitor: record every write strobe and flag back-to-back strobes.
    always @(negedge clk) begin
        if (cfg_we === 1'b1) begin
            if (we_n < 8) begin
                log_addr[we_n] = cfg_addr;
                log_data[we_n] = cfg_data;
                log_cyc[we_n]  = cyc;
            end
            we_n = we_n + 1;
            if (prev_we) b2b = 1'b1;
        end
        prev_we = (cfg_we === 1'b1);
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic clear_log();
        we_n   = 0;
        n_exp  = 0;
        b2b    = 1'b0;
        tb_crc = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        clear_log();
    endtask

    task automatic drive_bit(input logic b);
        if (gap_en) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(1, 0) == 0) break;
                @(negedge clk);
                din       = 1'($urandom_range(1, 0));
                din_valid = 1'b0;
            end
        end
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
    endtask

    task automatic send_frame(input logic [CFG_W-1:0] f, input logic bad_par);
        logic p;
        for (int i = CFG_W - 1; i >= 0; i--) begin
            drive_bit(f[i]);
            tb_crc = crc_step(tb_crc, f[i]);
        end
        p = (^f) ^ bad_par;
        drive_bit(p);
        tb_crc = crc_step(tb_crc, p);
        if (!bad_par && n_exp < 8) begin
            // Strobe must be visible in the cycle after the parity-sampling edge.
            exp_data[n_exp] = f;
            exp_cyc[n_exp]  = cyc + 1;
            n_exp++;
        end
    endtask

    task automatic finish_load();
`ifdef CLB_CFG_CRC_EN
        send_word({48'd0, tb_crc}, 16);
`endif
        idle(4);
    endtask

    task automatic check_log(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 64'(log_addr[i]), 64'(i));
            chk({tag, "_data"}, 64'(log_data[i]), 64'(exp_data[i]));
            chk({tag, "_lat"},  64'(log_cyc[i]),  64'(exp_cyc[i]));
        end
    endtask

    localparam logic [CFG_W-1:0] F0 = 37'h01_2345_6789;
    localparam logic [CFG_W-1:0] F1 = 37'h00_ABCD_EF01;
    localparam logic [CFG_W-1:0] F2 = 37'h1F_0F0F_0F0F;

    initial begin
`ifdef CLB_CFG_CRC_EN
        begin
            logic [15:0] c;
            logic [7:0]  s [9];
            c = 16'hFFFF;
            for (int k = 0; k < 9; k++) s[k] = 8'h31 + 8'(k);
            for (int k = 0; k < 9; k++)
                for (int j = 7; j >= 0; j--) c = crc_step(c, s[k][j]);
            chk("crc_model_check", 64'(c), 64'h29B1);
        end
`endif
        // Reset state.
        #12;
        chk("rst_cfg_data", 64'(cfg_data), 64'd0);
        chk("rst_cfg_addr", 64'(cfg_addr), 64'd0);
        chk("rst_cfg_we",   64'(cfg_we),   64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_err",      64'(err),      64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("idle_ignores_din", 64'(busy), 64'd0);

        // Nominal: two frames, continuous din_valid.
        pulse_start();
        chk("nom_busy_after_start", 64'(busy), 64'd1);
        send_word(64'hA5, 8);
        send_word(64'd2, 16);
        send_frame(F0, 1'b0);
        send_frame(F1, 1'b0);
        finish_load();
        chk("nom_we_count", 64'(we_n), 64'd2);
        check_log("nom", 2);
        chk("nom_done",     64'(done),     64'd1);
        chk("nom_err",      64'(err),      64'd0);
        chk("nom_busy",     64'(busy),     64'd0);
        chk("nom_err_code", 64'(err_code), 64'd0);
        chk("nom_no_b2b",   64'(b2b),      64'd0);

        // Gapped din_valid, one frame.
        gap_en = 1'b1;
        pulse_start();
        chk("gap_done_cleared", 64'(done), 64'd0);
        send_word(64'hA5, 8);
        send_word(64'd1, 16);
        send_frame(F2, 1'b0);
        gap_en = 1'b0;
        finish_load();
        chk("gap_we_count", 64'(we_n), 64'd1);
        check_log("gap", 1);
        chk("gap_done", 64'(done), 64'd1);

        // Parity error on frame 1 of 3.
        pulse_start();
        send_word(64'hA5, 8);
        send_word(64'd3, 16);
        send_frame(F0, 1'b0);
        send_frame(F1, 1'b1);
        send_frame(F2, 1'b0);
        idle(4);
        chk("par_we_count", 64'(we_n), 64'd1);
        chk("par_addr0",    64'(log_addr[0]), 64'd0);
        chk("par_err",      64'(err),      64'd1);
        chk("par_err_code", 64'(err_code), 64'd1);
        chk("par_busy",     64'(busy),     64'd0);
        chk("par_done",     64'(done),     64'd0);

        // Bad count 0.
        pulse_start();
        chk("cnt0_err_cleared", 64'(err), 64'd0);
        send_word(64'hA5, 8);
        send_word(64'd0, 16);
        send_frame(F0, 1'b0);
        idle(4);
        chk("cnt0_err",      64'(err),      64'd1);
        chk("cnt0_err_code", 64'(err_code), 64'd2);
        chk("cnt0_we_count", 64'(we_n),     64'd0);

        // Bad count NUM_CLB+1.
        pulse_start();
        send_word(64'hA5, 8);
        send_word(64'(NUM_CLB + 1), 16);
        send_frame(F1, 1'b0);
        idle(4);
        chk("cnt65_err",      64'(err),      64'd1);
        chk("cnt65_err_code", 64'(err_code), 64'd2);
        chk("cnt65_we_count", 64'(we_n),     64'd0);
        chk("cnt65_busy",     64'(busy),     64'd0);

        // Abort during frame 0: start together with a valid bit.
        pulse_start();
        send_word(64'hA5, 8);
        send_word(64'd1, 16);
        send_word(64'(F0 >> 27), 10);
        @(negedge clk);
        start     = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        din_valid = 1'b0;
        clear_log();
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_err",  64'(err),  64'd0);
        send_word(64'hA5, 8);
        send_word(64'd1, 16);
        send_frame(F1, 1'b0);
        finish_load();
        chk("abort_we_count", 64'(we_n), 64'd1);
        check_log("abort", 1);
        chk("abort_done", 64'(done), 64'd1);

        // Start while DONE clears done on the same edge.
        pulse_start();
        chk("rearm_done", 64'(done), 64'd0);
        chk("rearm_busy", 64'(busy), 64'd1);

        // Reset mid-frame after one completed write.
        pulse_start();
        send_word(64'hA5, 8);
        send_word(64'd2, 16);
        send_frame(F0, 1'b0);
        send_word(64'(F1 >> 17), 20);
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_cfg_data", 64'(cfg_data), 64'd0);
        chk("mrst_cfg_addr", 64'(cfg_addr), 64'd0);
        chk("mrst_busy",     64'(busy),     64'd0);
        chk("mrst_we",       64'(cfg_we),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("mrst_we_count", 64'(we_n), 64'd1);
        chk("mrst_done",     64'(done), 64'd0);

`ifdef CLB_CFG_CRC_EN
        // Corrupted CRC: all frames strobed, then CRC error.
        pulse_start();
        send_word(64'hA5, 8);
        send_word(64'd2, 16);
        send_frame(F0, 1'b0);
        send_frame(F2, 1'b0);
        send_word({48'd0, tb_crc ^ 16'h0004}, 16);
        idle(4);
        chk("crc_we_count", 64'(we_n),     64'd2);
        chk("crc_err",      64'(err),      64'd1);
        chk("crc_err_code", 64'(err_code), 64'd3);
        chk("crc_done",     64'(done),     64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
